// File: rtl/ov5640_sccb_pkg.sv
// ============================================================================
// Module      : ov5640_sccb_pkg
// Description : Shared types and constants for the OV5640 SCCB register writer
//               (FSM state enum, quarter-phase type, default device ID and the
//               transmit byte selector).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ov5640_sccb_pkg;

    // Transaction-level FSM states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        SHIFT = 3'd2,
        ACK   = 3'd3,
        STOP  = 3'd4,
        DONE  = 3'd5
    } sccb_state_t;

    // Quarter of an SCCB bit period (q0..q3)
    typedef logic [1:0] quarter_t;

    // OV5640 8-bit write ID (7-bit address 0x3C shifted, R/W=0)
    localparam logic [7:0] c_DEV_ID_DEFAULT = 8'h78;

    // Byte sent in slot idx of a 3-phase write: ID, addr hi, addr lo, data
    function automatic logic [7:0] sccb_byte_sel(
        input logic [1:0]  idx,
        input logic [7:0]  dev_id,
        input logic [15:0] addr,
        input logic [7:0]  data
    );
        logic [7:0] v;
        case (idx)
            2'd0:    v = dev_id;
            2'd1:    v = addr[15:8];
            2'd2:    v = addr[7:0];
            default: v = data;
        endcase
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sccb_tick_gen.sv
// ============================================================================
// Module      : sccb_tick_gen
// Description : Quarter-bit tick divider. Emits a one-cycle tick every CLK_DIV
//               clk_sys cycles; clr restarts the count so the first tick of a
//               transaction lands exactly CLK_DIV cycles after acceptance.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sccb_tick_gen #(
    parameter int CLK_DIV = 125
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] r_cnt;

    assign tick = (r_cnt == CW'(CLK_DIV - 1));

    // Free-running modulo-CLK_DIV counter, restarted by reset or clr
    always_ff @(posedge clk_sys) begin
        if (reset || clr) begin
            r_cnt <= '0;
        end else if (tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/ov5640_sccb_writer.sv
// ============================================================================
// Module      : ov5640_sccb_writer
// Description : Single-register SCCB write master for the OV5640. Sends
//               DEV_ID, addr[15:8], addr[7:0], data framed by start/stop, each
//               bit split into four quarter-phase ticks. SIOC is push-pull,
//               SIOD is open drain via siod_oe.
//               Optional feature macro: OV5640_SCCB_ACK_CHECK_EN
//               (when defined, a high SIOD at the ACK sample sets nack_err).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ov5640_sccb_writer
    import ov5640_sccb_pkg::*;
#(
    parameter int         CLK_DIV = 125,
    parameter logic [7:0] DEV_ID  = c_DEV_ID_DEFAULT
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        start_ov5640,
    input  logic [15:0] address_ov5640,
    input  logic [7:0]  data_ov5640,
    output logic        ready_ov5640,
    output logic        done_ov5640,
    output logic        sioc,
    output logic        siod_oe,
    input  logic        siod_in,
    output logic        nack_err
);

    sccb_state_t r_state, w_state_nxt;
    quarter_t    r_q, w_q_nxt;
    logic [2:0]  r_bit, w_bit_nxt;
    logic [1:0]  r_byte, w_byte_nxt;
    logic [15:0] r_addr;
    logic [7:0]  r_data;
    logic        r_sioc, r_siod_oe;
    logic        w_sioc, w_siod_oe;
    logic        w_tick;
    logic        w_accept;
    logic [7:0]  w_cur_byte;
    logic        w_cur_bit;

    assign w_accept     = (r_state == IDLE) && start_ov5640;
    // Drops in the request cycle itself so a registered requester cannot
    // fire a second start while the first is being taken
    assign ready_ov5640 = (r_state == IDLE) && !start_ov5640;
    assign done_ov5640  = (r_state == DONE);
    assign sioc         = r_sioc;
    assign siod_oe      = r_siod_oe;

    sccb_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk_sys (clk_sys),
        .reset   (reset),
        .clr     (w_accept),
        .tick    (w_tick)
    );

    assign w_cur_byte = sccb_byte_sel(r_byte, DEV_ID, r_addr, r_data);
    assign w_cur_bit  = w_cur_byte[3'd7 - r_bit];   // MSB first

    // State, quarter, bit and byte counters
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state <= IDLE;
            r_q     <= '0;
            r_bit   <= '0;
            r_byte  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_q     <= w_q_nxt;
            r_bit   <= w_bit_nxt;
            r_byte  <= w_byte_nxt;
        end
    end

    // Capture the write payload in the accepting cycle only
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_addr <= '0;
            r_data <= '0;
        end else if (w_accept) begin
            r_addr <= address_ov5640;
            r_data <= data_ov5640;
        end
    end

    // Next-state and line levels; lines are registered below to stay glitch-free
    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_bit_nxt   = r_bit;
        w_byte_nxt  = r_byte;
        w_sioc      = 1'b1;
        w_siod_oe   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_ov5640) begin
                    w_state_nxt = START;
                    w_q_nxt     = '0;
                    w_bit_nxt   = '0;
                    w_byte_nxt  = '0;
                end
            end
            START: begin
                w_sioc    = (r_q != 2'd3);
                w_siod_oe = r_q[1];
                if (w_tick) begin
                    w_q_nxt = r_q + 2'd1;
                    if (r_q == 2'd3) begin
                        w_state_nxt = SHIFT;
                        w_bit_nxt   = '0;
                    end
                end
            end
            SHIFT: begin
                w_sioc    = (r_q == 2'd1) || (r_q == 2'd2);
                w_siod_oe = !w_cur_bit;
                if (w_tick) begin
                    w_q_nxt = r_q + 2'd1;
                    if (r_q == 2'd3) begin
                        if (r_bit == 3'd7) begin
                            w_state_nxt = ACK;
                        end else begin
                            w_bit_nxt = r_bit + 3'd1;
                        end
                    end
                end
            end
            ACK: begin
                w_sioc    = (r_q == 2'd1) || (r_q == 2'd2);
                w_siod_oe = 1'b0;
                if (w_tick) begin
                    w_q_nxt = r_q + 2'd1;
                    if (r_q == 2'd3) begin
                        if (r_byte == 2'd3) begin
                            w_state_nxt = STOP;
                        end else begin
                            w_state_nxt = SHIFT;
                            w_byte_nxt  = r_byte + 2'd1;
                            w_bit_nxt   = '0;
                        end
                    end
                end
            end
            STOP: begin
                w_sioc    = (r_q != 2'd0);
                w_siod_oe = !r_q[1];
                if (w_tick) begin
                    w_q_nxt = r_q + 2'd1;
                    if (r_q == 2'd3) begin
                        w_state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Line drivers; reset releases the bus on the very next edge
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_sioc    <= 1'b1;
            r_siod_oe <= 1'b0;
        end else begin
            r_sioc    <= w_sioc;
            r_siod_oe <= w_siod_oe;
        end
    end

`ifdef OV5640_SCCB_ACK_CHECK_EN
    logic r_nack;

    // Sticky NACK flag: set on a high ACK sample at q2, cleared on a new start
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_nack <= 1'b0;
        end else if (w_accept) begin
            r_nack <= 1'b0;
        end else if ((r_state == ACK) && (r_q == 2'd2) && w_tick && siod_in) begin
            r_nack <= 1'b1;
        end
    end

    assign nack_err = r_nack;
`else
    // ACK slot is treated as the SCCB don't-care bit; SIOD is never read
    logic w_unused_siod;
    assign w_unused_siod = siod_in;
    assign nack_err      = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ov5640_sccb_writer.sv
// ============================================================================
// Module      : tb_ov5640_sccb_writer
// Description : Directed self-checking bench for ov5640_sccb_writer with
//               CLK_DIV=4. A passive bus monitor decodes SIOD bits on SIOC
//               rising edges and tracks start/stop conditions and bus-free time.
//               Honours OV5640_SCCB_ACK_CHECK_EN for the NACK expectations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ov5640_sccb_writer;

    localparam int CLK_DIV = 4;
    localparam int LAT     = 38 * 4 * CLK_DIV;   // 608 edges from accept to DONE
    localparam int LIMIT   = 2000;

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic        start_ov5640 = 1'b0;
    logic [15:0] address_ov5640 = '0;
    logic [7:0]  data_ov5640 = '0;
    logic        ready_ov5640;
    logic        done_ov5640;
    logic        sioc;
    logic        siod_oe;
    logic        siod_in = 1'b0;
    logic        nack_err;

    int n_checks = 0;
    int n_pass   = 0;

    ov5640_sccb_writer #(
        .CLK_DIV (CLK_DIV),
        .DEV_ID  (8'h78)
    ) dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .start_ov5640   (start_ov5640),
        .address_ov5640 (address_ov5640),
        .data_ov5640    (data_ov5640),
        .ready_ov5640   (ready_ov5640),
        .done_ov5640    (done_ov5640),
        .sioc           (sioc),
        .siod_oe        (siod_oe),
        .siod_in        (siod_in),
        .nack_err       (nack_err)
    );

    always #5 clk_sys = ~clk_sys;

    // ---------------- bus monitor (sampled on falling edge) ----------------
    logic rx [0:63];
    int   nbits    = 0;
    int   starts   = 0;
    int   stops    = 0;
    int   run      = 0;
    int   last_gap = 0;
    logic p_sioc   = 1'b1;
    logic p_oe     = 1'b0;

    always @(negedge clk_sys) begin
        if (p_sioc && sioc && !p_oe && siod_oe) begin
            starts   = starts + 1;
            last_gap = run;
            nbits    = 0;
        end
        if (p_sioc && sioc && p_oe && !siod_oe) begin
            stops = stops + 1;
        end
        if (!p_sioc && sioc && nbits < 64) begin
            rx[nbits] = ~siod_oe;
            nbits     = nbits + 1;
        end
        if (sioc && !siod_oe) run = run + 1;
        else                  run = 0;
        p_sioc = sioc;
        p_oe   = siod_oe;
    end

    function automatic logic [7:0] rx_byte(input int k);
        logic [7:0] b;
        b = '0;
        for (int i = 0; i < 8; i++) b = {b[6:0], rx[k * 9 + i]};
        return b;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass = n_pass + 1;
        end
    endtask

    // One write; optionally injects a foreign start inject_at edges in.
    // Called #1 after a rising edge; returns #1 after the edge following DONE.
    task automatic do_write(input logic [15:0] a, input logic [7:0] d, input int inject_at,
                            output int lat, output logic nack_acc, output logic nack_mid);
        int   n;
        logic rdy_seen;
        address_ov5640 = a;
        data_ov5640    = d;
        start_ov5640   = 1'b1;
        #1;
        check("ready_drops_in_start_cycle", ready_ov5640, 1'b0);
        @(posedge clk_sys); #1;
        start_ov5640   = 1'b0;
        address_ov5640 = '0;
        data_ov5640    = '0;
        nack_acc = nack_err;
        nack_mid = 1'b0;
        n        = 0;
        rdy_seen = 1'b0;
        while (!done_ov5640 && n < LIMIT) begin
            if (ready_ov5640) rdy_seen = 1'b1;
            if (n == inject_at) begin
                start_ov5640   = 1'b1;
                address_ov5640 = 16'h4300;
                data_ov5640    = 8'h55;
            end else begin
                start_ov5640   = 1'b0;
                address_ov5640 = '0;
                data_ov5640    = '0;
            end
            @(posedge clk_sys); #1;
            n = n + 1;
            if (n == 160) nack_mid = nack_err;
        end
        start_ov5640 = 1'b0;
        lat = n;
        check("ready_low_while_busy", rdy_seen, 1'b0);
        check("ready_low_in_done", ready_ov5640, 1'b0);
        @(posedge clk_sys); #1;
        check("done_one_cycle", done_ov5640, 1'b0);
        check("ready_after_done", ready_ov5640, 1'b1);
    endtask

    // Compare the decoded frame: 4x(8 data + ACK slot) plus the stop SIOC pulse
    task automatic check_frame(input logic [15:0] a, input logic [7:0] d);
        check("bit_count", nbits, 37);
        check("byte0_dev_id", rx_byte(0), 8'h78);
        check("byte1_addr_hi", rx_byte(1), a[15:8]);
        check("byte2_addr_lo", rx_byte(2), a[7:0]);
        check("byte3_data", rx_byte(3), d);
        check("ack_slot_released", rx[8], 1'b1);
    endtask

    initial begin
        int   lat;
        int   s0;
        int   st0;
        int   n;
        logic na;
        logic nm;
        logic seen;
        logic exp_nack;

`ifdef OV5640_SCCB_ACK_CHECK_EN
        exp_nack = 1'b1;
`else
        exp_nack = 1'b0;
`endif

        // ---- reset state ----
        repeat (3) @(posedge clk_sys);
        #1;
        check("rst_sioc", sioc, 1'b1);
        check("rst_siod_oe", siod_oe, 1'b0);
        check("rst_done", done_ov5640, 1'b0);
        check("rst_nack", nack_err, 1'b0);
        reset = 1'b0;
        #1;
        check("rst_ready", ready_ov5640, 1'b1);
        @(posedge clk_sys); #1;

        // ---- basic write ----
        s0  = starts;
        st0 = stops;
        do_write(16'h3008, 8'h82, -1, lat, na, nm);
        check("basic_latency", lat, LAT);
        check_frame(16'h3008, 8'h82);
        check("basic_one_start", starts - s0, 1);
        check("basic_one_stop", stops - st0, 1);

        // ---- start while busy is ignored ----
        do_write(16'h3103, 8'h11, 200, lat, na, nm);
        check("busy_latency", lat, LAT);
        check_frame(16'h3103, 8'h11);
        s0   = starts;
        seen = 1'b0;
        repeat (100) begin
            @(posedge clk_sys); #1;
            if (!ready_ov5640 || done_ov5640) seen = 1'b1;
        end
        check("busy_no_queued_write", starts - s0, 0);
        check("busy_stays_idle", seen, 1'b0);

        // ---- NACK: SIOD held high at every ACK ----
        siod_in = 1'b1;
        do_write(16'h3820, 8'h40, -1, lat, na, nm);
        check("nack_latency_unchanged", lat, LAT);
        check("nack_after_first_ack", nm, exp_nack);
        check("nack_sticky_idle", nack_err, exp_nack);
        check_frame(16'h3820, 8'h40);
        siod_in = 1'b0;

        // ---- next start clears nack, then back-to-back write ----
        do_write(16'h4740, 8'h21, -1, lat, na, nm);
        check("nack_cleared_on_start", na, 1'b0);
        check("b2b_first_latency", lat, LAT);
        s0 = starts;
        do_write(16'h5001, 8'hA5, -1, lat, na, nm);
        check("b2b_second_latency", lat, LAT);
        check_frame(16'h5001, 8'hA5);
        check("b2b_second_start_seen", starts - s0, 1);
        check("b2b_bus_free_time", (last_gap >= 4 * CLK_DIV), 1'b1);

        // ---- reset in the middle of byte 2 ----
        s0 = starts;
        address_ov5640 = 16'h3a0c;
        data_ov5640    = 8'h7e;
        start_ov5640   = 1'b1;
        @(posedge clk_sys); #1;
        start_ov5640 = 1'b0;
        n = 0;
        while (!((starts > s0) && (nbits >= 20)) && n < LIMIT) begin
            @(posedge clk_sys); #1;
            n = n + 1;
        end
        check("abort_reached_byte2", (n < LIMIT), 1'b1);
        reset = 1'b1;
        @(posedge clk_sys); #1;
        check("abort_sioc", sioc, 1'b1);
        check("abort_siod_oe", siod_oe, 1'b0);
        check("abort_ready", ready_ov5640, 1'b1);
        reset = 1'b0;
        seen  = 1'b0;
        repeat (700) begin
            @(posedge clk_sys); #1;
            if (done_ov5640 || !sioc || siod_oe) seen = 1'b1;
        end
        check("abort_no_resume", seen, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ov5640_sccb_writer.md
OV5640_SCCB_WRITER -- requirements
Module: ov5640_sccb_writer

Interface
REQ-001 SHALL have parameter CLK_DIV, default 125, the number of clk_sys cycles per quarter SCCB bit.
REQ-002 SHALL have parameter DEV_ID, default 8'h78, the OV5640 8-bit SCCB write ID.
REQ-003 SHALL have port clk_sys, input, 1 bit, the single system clock.
REQ-004 SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-005 SHALL have port start_ov5640, input, 1 bit, a one-cycle write request.
REQ-006 SHALL have port address_ov5640, input, 16 bits, the sensor register address, valid while start_ov5640 is high.
REQ-007 SHALL have port data_ov5640, input, 8 bits, the register data, valid while start_ov5640 is high.
REQ-008 SHALL have port ready_ov5640, output, 1 bit, high when the block can accept a new start.
REQ-009 SHALL have port done_ov5640, output, 1 bit, a one-cycle pulse when a transaction completes.
REQ-010 SHALL have port sioc, output, 1 bit, the SCCB clock, driven push-pull.
REQ-011 SHALL have port siod_oe, output, 1 bit, where 1 means pull SIOD low (open drain) and 0 means release SIOD.
REQ-012 SHALL have port siod_in, input, 1 bit, the sampled SIOD pad level.
REQ-013 SHALL have port nack_err, output, 1 bit, a sticky acknowledge-error flag.

Function
REQ-014 SHALL compute ready_ov5640 = (state==IDLE) & !start_ov5640, combinationally, so that the upstream registered read-request cannot issue a second start during acceptance.
REQ-015 SHALL, when start_ov5640=1 in IDLE, latch address_ov5640 and data_ov5640 in that cycle and enter START on the next edge.
REQ-016 SHALL ignore start_ov5640 outside IDLE; no queuing and no corruption of the active transfer.
REQ-017 SHALL advance the bit engine only on a tick, produced once every CLK_DIV clk_sys cycles; the tick counter SHALL be cleared on acceptance.
REQ-018 SHALL use the FSM states IDLE, START, SHIFT, ACK, STOP and DONE.
REQ-019 SHALL have each of START, each SHIFT bit, each ACK bit and STOP last exactly 4 ticks, indexed by quarter phase q=0..3.
REQ-020 SHALL drive START as: q0-1 SIOD released with SIOC high; q2 SIOD low with SIOC high; q3 SIOC low.
REQ-021 SHALL drive SHIFT as: q0 SIOC low with SIOD set to the current bit; q1-2 SIOC high; q3 SIOC low.
REQ-022 SHALL transmit bits MSB first.
REQ-023 SHALL send bytes in the order DEV_ID, address[15:8], address[7:0], data, using a byte index 0..3.
REQ-024 SHALL, in ACK, release SIOD, use the same SIOC pattern as SHIFT, and sample siod_in at the q2 tick.
REQ-025 SHALL go from ACK to SHIFT when byte index < 3, and to STOP after byte 3.
REQ-026 SHALL drive STOP as: q0 SIOD low with SIOC low; q1 SIOC high; q2-3 SIOD released with SIOC high.
REQ-027 SHALL make DONE last 1 cycle: done_ov5640=1, then IDLE.
REQ-028 SHALL take a transaction 38*4*CLK_DIV cycles from acceptance to done_ov5640, plus 1 cycle for DONE.
REQ-029 SHALL release the SIOC/SIOD lines (sioc=1, siod_oe=0) in IDLE.

Reset
REQ-030 SHALL, with reset=1 at a clk_sys edge, place the FSM in IDLE with sioc=1, siod_oe=0, done_ov5640=0, nack_err=0, and the counters and latches zeroed.
REQ-031 SHALL abort any transaction when reset arrives mid-transaction, with lines released the next cycle and no stop condition generated.

Configuration
REQ-032 SHALL provide the macro OV5640_SCCB_ACK_CHECK_EN.
REQ-033 SHALL, with OV5640_SCCB_ACK_CHECK_EN defined, set nack_err when siod_in=1 at an ACK q2 sample; the flag clears only on reset or on the next accepted start.
REQ-034 SHALL, with OV5640_SCCB_ACK_CHECK_EN defined, continue a transfer after a NACK with no change in timing.
REQ-035 SHALL, without OV5640_SCCB_ACK_CHECK_EN, treat ACK as a don't-care bit (SCCB X-bit), tie nack_err to 0, and leave siod_in unused.

Structure
REQ-036 SHALL define the state enum, the quarter-phase type and the DEV_ID default constant in package ov5640_sccb_pkg.
REQ-037 SHALL implement the divider as sub-module sccb_tick_gen (inputs clk_sys, reset, clr; output tick).

Verification
REQ-038 SHALL cover a basic write: CLK_DIV=4, start with addr 16'h3008, data 8'h82 -> SIOD serial 0x78,X,0x30,X,0x08,X,0x82,X framed by start/stop, done at cycle 609 after acceptance.
REQ-039 SHALL cover the ready handshake: ready_ov5640 drops in the start cycle, stays low through DONE, and rises the cycle after done.
REQ-040 SHALL cover a start while busy: a second start with addr 16'h4300 mid-transfer is ignored and the first transfer's bytes are unchanged.
REQ-041 SHALL cover NACK (macro on): siod_in held 1 -> nack_err=1 after the first ACK; the next start clears nack_err.
REQ-042 SHALL cover reset mid-transfer: reset during byte 2 -> next cycle IDLE, sioc=1, siod_oe=0, ready_ov5640=1.
REQ-043 SHALL cover back-to-back writes: start asserted the cycle after done -> accepted, with no gap violations between the stop and the start condition.
